// File: rtl/clock_pkg.sv
// Shared constants and the state type for the time-of-day counter.
package clock_pkg;

  localparam int HOURS_PER_DAY = 24;
  localparam int MINS_PER_HOUR = 60;
  localparam int SECS_PER_MIN  = 60;

  typedef enum logic [1:0] {
    TK_UNSET,
    TK_RUN,
    TK_HOLD
  } tk_state_t;

endpackage

// File: rtl/mod_counter.sv
// Modulo-MOD counter with synchronous load.
// Load wins over enable. The carry output is combinational and is high when
// the counter is enabled and about to wrap, so counters can be chained.
module mod_counter #(
  parameter int MOD = 60,
  parameter int W   = 6
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  output logic [W-1:0] count,
  output logic         carry
);

  logic [W-1:0] r_count;

  // Count register: async clear, sync load, wrap at MOD-1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (ld) begin
      r_count <= ld_val;
    end else if (en) begin
      if (r_count == W'(MOD - 1)) r_count <= '0;
      else                        r_count <= r_count + W'(1);
    end
  end

  assign count = r_count;
  assign carry = en && (r_count == W'(MOD - 1));

endmodule

// File: rtl/time_keeper.sv
// Running HH:MM:SS time-of-day counter (24 h, binary fields).
// A prescaler divides clk down to a 1 Hz tick while in RUN.
// The secs -> mins -> hours chain advances on that tick.
// Load takes a new HH:MM (out-of-range fields become 0) and restarts the prescaler phase.
//
// Handshake: there is no valid/ready pair here. load is a single-cycle strobe
// sampled on the rising clk edge, and hold is a level sampled on every edge.
// All outputs change one edge after the input that caused them.
module time_keeper
  import clock_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic      clk,
  input  logic      reset_n,
  input  logic      load,
  input  logic      hold,
  input  logic [7:0] set_hours,
  input  logic [7:0] set_mins,
  output logic [7:0] hours,
  output logic [7:0] mins,
  output logic [7:0] secs,
  output logic      sec_pulse,
  output logic      day_wrap,
  output logic      time_valid,
  output tk_state_t dbg_state
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

  tk_state_t   r_state;
  logic [PW-1:0] r_presc;
  logic        r_sec_pulse;
  logic        r_day_wrap;
  logic        r_time_valid;

  logic [4:0]  w_hours;
  logic [5:0]  w_mins;
  logic [5:0]  w_secs;
  logic [4:0]  w_hours_ld;
  logic [5:0]  w_mins_ld;
  logic        w_tick;
  logic        w_secs_carry;
  logic        w_mins_carry;
  logic        w_hours_carry;

  // Out-of-range set values load as zero for that field.
  assign w_hours_ld = (set_hours < 8'(HOURS_PER_DAY)) ? set_hours[4:0] : 5'd0;
  assign w_mins_ld  = (set_mins  < 8'(MINS_PER_HOUR)) ? set_mins[5:0]  : 6'd0;

  // A tick that coincides with a load is dropped.
  assign w_tick = (r_state == TK_RUN) && (r_presc == PW'(CLK_HZ - 1)) && !load;

  // Prescaler: runs only in RUN, keeps its phase across HOLD, and is cleared by load.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_presc <= '0;
    end else if (load) begin
      r_presc <= '0;
    end else if (r_state == TK_RUN) begin
      if (r_presc == PW'(CLK_HZ - 1)) r_presc <= '0;
      else                            r_presc <= r_presc + PW'(1);
    end
  end

  // Mode FSM together with its registered pulse and valid outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= TK_UNSET;
      r_sec_pulse  <= 1'b0;
      r_day_wrap   <= 1'b0;
      r_time_valid <= 1'b0;
    end else begin
      r_sec_pulse <= w_tick;
      r_day_wrap  <= w_hours_carry;
      case (r_state)
        TK_UNSET: begin
          if (load) begin
            r_state      <= hold ? TK_HOLD : TK_RUN;
            r_time_valid <= 1'b1;
          end
        end
        TK_RUN:  if (hold)  r_state <= TK_HOLD;
        TK_HOLD: if (!hold) r_state <= TK_RUN;
        default: r_state <= TK_UNSET;
      endcase
    end
  end

  mod_counter #(.MOD(SECS_PER_MIN), .W(6)) u_secs (
    .clk    (clk),
    .reset_n(reset_n),
    .en     (w_tick),
    .ld     (load),
    .ld_val (6'd0),
    .count  (w_secs),
    .carry  (w_secs_carry)
  );

  mod_counter #(.MOD(MINS_PER_HOUR), .W(6)) u_mins (
    .clk    (clk),
    .reset_n(reset_n),
    .en     (w_secs_carry),
    .ld     (load),
    .ld_val (w_mins_ld),
    .count  (w_mins),
    .carry  (w_mins_carry)
  );

  mod_counter #(.MOD(HOURS_PER_DAY), .W(5)) u_hours (
    .clk    (clk),
    .reset_n(reset_n),
    .en     (w_mins_carry),
    .ld     (load),
    .ld_val (w_hours_ld),
    .count  (w_hours),
    .carry  (w_hours_carry)
  );

  assign hours      = {3'b000, w_hours};
  assign mins       = {2'b00, w_mins};
  assign secs       = {2'b00, w_secs};
  assign sec_pulse  = r_sec_pulse;
  assign day_wrap   = r_day_wrap;
  assign time_valid = r_time_valid;
  assign dbg_state  = r_state;

endmodule
